// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Brief    : FWFT result FIFO behind the 16-bit ALU, with sticky status flags.
//            Optional ALU_FIFO_OVF_COUNT_EN adds a saturating overflow counter.
// Revision : 1.0  initial release
// ============================================================================
module alu_result_fifo #(
   parameter int NUMBITS = 16,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUMBITS-1:0]         in_result,
   input  logic                       in_carry,
   input  logic                       in_overflow,
   input  logic                       in_zero,
   input  logic [2:0]                 in_opcode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUMBITS-1:0]         out_result,
   output logic                       out_carry,
   output logic                       out_overflow,
   output logic                       out_zero,
   output logic [2:0]                 out_opcode,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   input  logic                       clr_sticky,
   output logic                       sticky_carry,
   output logic                       sticky_overflow,
   output logic                       sticky_drop
`ifdef ALU_FIFO_OVF_COUNT_EN
  ,output logic [7:0]                 ovf_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = NUMBITS + 6;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [EW-1:0] w_head;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && out_ready;
   // A push into a full FIFO is still honoured when the head leaves the same cycle.
   assign w_push  = in_valid && (!w_full || w_pop);
   assign w_drop  = in_valid && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_result, in_carry, in_overflow, in_zero, in_opcode};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   // Set beats clear so an event in the clearing cycle is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky_carry    <= 1'b0;
         sticky_overflow <= 1'b0;
         sticky_drop     <= 1'b0;
      end else begin
         if (w_push && in_carry)    sticky_carry <= 1'b1;
         else if (clr_sticky)       sticky_carry <= 1'b0;
         if (w_push && in_overflow) sticky_overflow <= 1'b1;
         else if (clr_sticky)       sticky_overflow <= 1'b0;
         if (w_drop)                sticky_drop <= 1'b1;
         else if (clr_sticky)       sticky_drop <= 1'b0;
      end
   end

`ifdef ALU_FIFO_OVF_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_count <= 8'd0;
      end else if (clr_sticky) begin
         ovf_count <= (w_push && in_overflow) ? 8'd1 : 8'd0;
      end else if (w_push && in_overflow && ovf_count != 8'hFF) begin
         ovf_count <= ovf_count + 8'd1;
      end
   end
`endif

   assign w_head       = r_mem[r_rd_ptr];
   assign out_result   = w_head[EW-1:6];
   assign out_carry    = w_head[5];
   assign out_overflow = w_head[4];
   assign out_zero     = w_head[3];
   assign out_opcode   = w_head[2:0];
   assign out_valid    = !w_empty;
   assign in_ready     = !w_full;
   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_fifo
// Brief    : Scoreboard bench for alu_result_fifo (directed vectors).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_carry, in_overflow, in_zero;
   logic [15:0] in_result, out_result;
   logic [2:0]  in_opcode, out_opcode;
   logic        out_valid, out_ready, out_carry, out_overflow, out_zero;
   logic [2:0]  count;
   logic        full, empty, clr_sticky;
   logic        sticky_carry, sticky_overflow, sticky_drop;
`ifdef ALU_FIFO_OVF_COUNT_EN
   logic [7:0]  ovf_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [21:0] exp_q[$];

   alu_result_fifo #(.NUMBITS(16), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_carry(in_carry), .in_overflow(in_overflow), .in_zero(in_zero),
      .in_opcode(in_opcode),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
      .out_opcode(out_opcode),
      .count(count), .full(full), .empty(empty), .clr_sticky(clr_sticky),
      .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
      .sticky_drop(sticky_drop)
`ifdef ALU_FIFO_OVF_COUNT_EN
     ,.ovf_count(ovf_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a push; record it in the scoreboard only if it will be accepted.
   task automatic drive(input logic [15:0] r, input logic c, input logic o,
                        input logic z, input logic [2:0] op, input bit accept);
      in_valid    = 1'b1;
      in_result   = r;
      in_carry    = c;
      in_overflow = o;
      in_zero     = z;
      in_opcode   = op;
      if (accept) exp_q.push_back({r, c, o, z, op});
   endtask

   // Monitor: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no entry", out_result);
         end else begin
            if ({out_result, out_carry, out_overflow, out_zero, out_opcode} !== exp_q[0]) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h",
                        {out_result, out_carry, out_overflow, out_zero, out_opcode}, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
      in_overflow = 1'b0; in_zero = 1'b0; in_opcode = '0;
      out_ready = 1'b0; clr_sticky = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      step();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sticky", {sticky_carry, sticky_overflow, sticky_drop}, 0);

      // single entry
      drive(16'h1234, 1, 0, 0, 3'b000, 1);
      step();
      in_valid = 1'b0;
      check("single_out_valid", out_valid, 1);
      check("single_sticky_carry", sticky_carry, 1);
      check("single_count", count, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("single_empty", empty, 1);

      // fill, fifth push dropped
      for (int i = 1; i <= 5; i++) begin
         drive(16'(i), 0, 0, (i == 3), 3'(i), i <= 4);
         step();
      end
      in_valid = 1'b0;
      check("fill_full", full, 1);
      check("fill_count", count, 4);
      check("fill_in_ready", in_ready, 0);
      check("fill_sticky_drop", sticky_drop, 1);

      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      check("clr_drop", sticky_drop, 0);
      check("clr_carry", sticky_carry, 0);

      // push and pop together while full
      drive(16'hAAAA, 0, 0, 0, 3'b111, 1);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("fullpp_count", count, 4);
      check("fullpp_no_drop", sticky_drop, 0);
      out_ready = 1'b1;
      repeat (4) step();
      check("drain_empty", empty, 1);

      // pop while empty is ignored
      step();
      check("empty_pop_count", count, 0);

      // wrap-around with paired push/pop
      for (int i = 0; i < 10; i++) begin
         drive(16'(i), 0, 0, 0, 3'(i), 1);
         step();
         check("wrap_count", count, 1);
      end
      in_valid = 1'b0;
      step();
      check("wrap_empty", empty, 1);

      // clear and set in the same cycle: set wins
      clr_sticky = 1'b1;
      drive(16'h5555, 0, 1, 0, 3'b010, 1);
      step();
      in_valid = 1'b0;
      check("clr_vs_set_ovf", sticky_overflow, 1);
`ifdef ALU_FIFO_OVF_COUNT_EN
      check("clr_vs_set_cnt", ovf_count, 1);
`endif
      step();
      clr_sticky = 1'b0;
      check("clr_alone_ovf", sticky_overflow, 0);

`ifdef ALU_FIFO_OVF_COUNT_EN
      for (int i = 0; i < 300; i++) begin
         drive(16'(i), 0, 1, 0, 3'b001, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      check("ovf_count_sat", ovf_count, 255);
`endif

      // mid-operation reset empties the FIFO immediately
      out_ready = 1'b0;
      drive(16'hBEEF, 1, 0, 0, 3'b011, 0);
      step();
      step();
      in_valid = 1'b0;
      check("pre_reset_count", count, 2);
      reset = 1'b0;
      #1;
      check("async_reset_empty", empty, 1);
      check("async_reset_sticky", sticky_carry, 0);
      step();
      reset = 1'b1;
      step();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
